// File: rtl/vde_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : vde_pkg                                                     |
// | Brief    : Shared constants and state type for the VDE bump batcher.   |
// | Revision : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package vde_pkg;
   localparam int BATCH_MAX = 8;
   localparam int VAR_W     = 32;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      WAIT_VDE = 2'd1,
      ISSUE    = 2'd2,
      HOLDOFF  = 2'd3
   } bb_state_e;
endpackage
`default_nettype wire

// File: rtl/vde_bump_batcher_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface: vde_bump_batcher_if                                         |
// | Brief    : Learned-literal stream in, packed bump batch out.           |
// | Revision : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
interface vde_bump_batcher_if;
   import vde_pkg::*;

   logic                             in_valid;
   logic                             in_ready;
   logic [VAR_W-1:0]                 in_var;
   logic                             in_last;
   logic [CNT_W-1:0]                 bump_count;
   logic [BATCH_MAX-1:0][VAR_W-1:0]  bump_vars;
   logic                             decay;

   modport master (
      output in_valid, in_var, in_last,
      input  in_ready, bump_count, bump_vars, decay
   );

   modport slave (
      input  in_valid, in_var, in_last,
      output in_ready, bump_count, bump_vars, decay
   );
endinterface
`default_nettype wire

// File: rtl/vde_bump_batcher.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : vde_bump_batcher                                            |
// | Brief    : Collects deduplicated learned-clause vars into 8-slot bump  |
// |            batches, issued once the VDE is idle, with clause decay.    |
// | Revision : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module vde_bump_batcher #(
   parameter int BATCH_MAX = vde_pkg::BATCH_MAX
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   vde_bump_batcher_if.slave               bif,
   input  wire logic [vde_pkg::VAR_W-1:0]  max_var,
   input  wire logic                       flush,
   input  wire logic                       vde_pending_ops,
   output logic                            busy
);
   import vde_pkg::*;

   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BATCH_MAX);

   bb_state_e                       r_state;
   bb_state_e                       w_state_nxt;
   logic                            w_issue_nxt;
   logic [CNT_W-1:0]                r_count;
   logic [VAR_W-1:0]                r_slot [BATCH_MAX];
   logic                            r_last_seen;
   logic [CNT_W-1:0]                r_bump_count;
   logic [BATCH_MAX-1:0][VAR_W-1:0] r_bump_vars;
   logic                            r_decay;
   logic [BATCH_MAX-1:0]            w_dup;
   logic                            w_accept;
   logic                            w_in_range;
   logic                            w_store;
   logic                            w_close;

   assign bif.in_ready = (r_state == COLLECT) && !flush;
   assign w_accept     = bif.in_valid && bif.in_ready;
   assign busy         = (r_state != COLLECT) || (r_count != '0);

   generate
      for (genvar g = 0; g < BATCH_MAX; g++) begin : g_dup
         assign w_dup[g] = (CNT_W'(g) < r_count) && (r_slot[g] == bif.in_var);
      end
   endgenerate

   assign w_in_range = (bif.in_var != '0) && (bif.in_var <= max_var);
   assign w_store    = w_accept && w_in_range && !(|w_dup);
   assign w_close    = w_accept && (bif.in_last || (w_store && (r_count + 1'b1 == C_FULL)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= COLLECT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue_nxt = 1'b0;
      case (r_state)
         COLLECT:  if (w_close) w_state_nxt = WAIT_VDE;
         WAIT_VDE: if (!vde_pending_ops) w_state_nxt = ISSUE;
         ISSUE:    w_state_nxt = HOLDOFF;
         HOLDOFF:  w_state_nxt = COLLECT;
         default:  w_state_nxt = COLLECT;
      endcase
      if (flush) w_state_nxt = COLLECT;
      w_issue_nxt = (w_state_nxt == ISSUE);
   end

   // Batch storage; HOLDOFF empties it so the next batch starts clean.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count     <= '0;
         r_last_seen <= 1'b0;
         for (int i = 0; i < BATCH_MAX; i++) r_slot[i] <= '0;
      end else if (flush || (r_state == HOLDOFF)) begin
         r_count     <= '0;
         r_last_seen <= 1'b0;
         for (int i = 0; i < BATCH_MAX; i++) r_slot[i] <= '0;
      end else if (r_state == COLLECT) begin
         for (int i = 0; i < BATCH_MAX; i++) begin
            if (w_store && (r_count == CNT_W'(i))) r_slot[i] <= bif.in_var;
         end
         if (w_store)                 r_count     <= r_count + 1'b1;
         if (w_accept && bif.in_last) r_last_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bump_count <= '0;
         r_bump_vars  <= '0;
         r_decay      <= 1'b0;
      end else begin
         r_bump_count <= '0;
         r_bump_vars  <= '0;
         r_decay      <= 1'b0;
         if (w_issue_nxt) begin
            r_bump_count <= r_count;
            for (int i = 0; i < BATCH_MAX; i++) r_bump_vars[i] <= r_slot[i];
            r_decay <= r_last_seen;
         end
      end
   end

   // A flush landing on the issue cycle suppresses the pulse already on the outputs.
   assign bif.bump_count = flush ? '0 : r_bump_count;
   assign bif.bump_vars  = flush ? '0 : r_bump_vars;
   assign bif.decay      = flush ? 1'b0 : r_decay;
endmodule
`default_nettype wire
